// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: pending/mask registers, lowest-bit-first
// selection and an IDLE -> REQ -> SERV handshake with the core.

module int_ctrl_pend_bit (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);
  // set dominates clr so a re-request in the ack cycle is not lost
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= (q & ~clr) | set;
  end
endmodule

module int_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter logic [31:0] MASK_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_set_in,
  input  logic [31:0] int_type_in,
  input  logic [31:0] ext_irq,
  input  logic        iret_in,
  input  logic        mask_we,
  input  logic [31:0] mask_in,
  output logic [31:0] mask_out,
  output logic [31:0] pending_out,
  output logic        irq_valid,
  output logic [4:0]  irq_id,
  output logic [31:0] irq_vector,
  input  logic        irq_ack,
  output logic        in_service
);
  localparam int NUM_SRC = 32;

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t              state, state_nxt;
  logic [4:0]          id_nxt, sel_id;
  logic [NUM_SRC-1:0]  pending, mask, set, clr, eligible;

  assign set = ext_irq | (int_set_in ? int_type_in : '0);
  assign clr = (state == REQ && irq_ack) ? (32'd1 << irq_id) : '0;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_pend
    int_ctrl_pend_bit u_pend (
      .clk (clk),
      .rst (rst),
      .set (set[i]),
      .clr (clr[i]),
      .q   (pending[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)          mask <= MASK_RST;
    else if (mask_we) mask <= mask_in;
  end

  assign eligible = pending & mask;

  // descending scan so the lowest set bit is the last one written
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (eligible[i]) sel_id = 5'(i);
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    case (state)
      IDLE: if (eligible != '0) begin
        state_nxt = REQ;
        id_nxt    = sel_id;
      end
      REQ:  if (irq_ack) state_nxt = SERV;
      SERV: if (iret_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_nxt;
      irq_id <= id_nxt;
    end
  end

  assign irq_valid   = (state == REQ);
  assign in_service  = (state == SERV);
  assign irq_vector  = VEC_BASE + {25'd0, irq_id, 2'b00};
  assign mask_out    = mask;
  assign pending_out = pending;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: per-cycle comparison against a behavioural
// model plus literal checkpoints taken from hand-worked scenarios.

module tb_int_ctrl;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;
  localparam logic [31:0] MASK_RST = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, int_set_in, iret_in, mask_we, irq_ack;
  logic [31:0] int_type_in, ext_irq, mask_in;
  logic [31:0] mask_out, pending_out, irq_vector;
  logic        irq_valid, in_service;
  logic [4:0]  irq_id;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int_ctrl #(.VEC_BASE(VEC_BASE), .MASK_RST(MASK_RST)) dut (
    .clk(clk), .rst(rst), .int_set_in(int_set_in), .int_type_in(int_type_in),
    .ext_irq(ext_irq), .iret_in(iret_in), .mask_we(mask_we), .mask_in(mask_in),
    .mask_out(mask_out), .pending_out(pending_out), .irq_valid(irq_valid),
    .irq_id(irq_id), .irq_vector(irq_vector), .irq_ack(irq_ack),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  // model: a request is either being presented, being serviced, or neither
  logic [31:0] m_pend, m_mask;
  logic        m_valid, m_serv;
  int          m_id;

  function automatic int lowest(input logic [31:0] e);
    logic [31:0] lb;
    lb = e & (~e + 32'd1);
    return $clog2(lb);
  endfunction

  function automatic logic [31:0] bit_at(input int n);
    return 32'd1 << n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= '0; m_mask <= MASK_RST; m_valid <= 1'b0; m_serv <= 1'b0; m_id <= 0;
    end else begin
      m_pend <= (m_pend & ~((m_valid && irq_ack) ? bit_at(m_id) : 32'd0))
              | ext_irq | (int_set_in ? int_type_in : 32'd0);
      if (mask_we) m_mask <= mask_in;
      if (!m_valid && !m_serv && (m_pend & m_mask) != 0) begin
        m_valid <= 1'b1;
        m_id    <= lowest(m_pend & m_mask);
      end else if (m_valid && irq_ack) begin
        m_valid <= 1'b0;
        m_serv  <= 1'b1;
      end else if (m_serv && iret_in) begin
        m_serv  <= 1'b0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_mask",    mask_out,           m_mask);
      cmp("model_pending", pending_out,        m_pend);
      cmp("model_valid",   32'(irq_valid),     32'(m_valid));
      cmp("model_serv",    32'(in_service),    32'(m_serv));
      cmp("model_id",      32'(irq_id),        32'(m_id));
      cmp("model_vector",  irq_vector,         VEC_BASE + 32'(m_id * 4));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_set_in = 0; int_type_in = '0; ext_irq = '0; iret_in = 0;
    mask_we = 0; mask_in = '0; irq_ack = 0;
  endtask

  task automatic ack_cycle();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  task automatic iret_cycle();
    iret_in = 1; tick(); iret_in = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(2);
    rst = 0;
    chk_en = 1'b1;
    cmp("rst_valid",   32'(irq_valid),  32'd0);
    cmp("rst_serv",    32'(in_service), 32'd0);
    cmp("rst_pending", pending_out,     32'd0);
    cmp("rst_mask",    mask_out,        32'hFFFF_FFFF);
    cmp("rst_vector",  irq_vector,      32'h100);

    // software interrupt on source 3
    int_set_in = 1; int_type_in = 32'h8; tick(); idle_inputs();
    cmp("sw_pending", pending_out, 32'h8);
    cmp("sw_valid_early", 32'(irq_valid), 32'd0);
    tick();
    cmp("sw_valid",  32'(irq_valid), 32'd1);
    cmp("sw_id",     32'(irq_id),    32'd3);
    cmp("sw_vector", irq_vector,     32'h10C);
    tick(3);
    cmp("sw_hold", 32'(irq_valid), 32'd1);
    ack_cycle();
    cmp("sw_serv",       32'(in_service), 32'd1);
    cmp("sw_valid_drop", 32'(irq_valid),  32'd0);
    cmp("sw_clr",        pending_out,     32'd0);
    tick();
    iret_cycle();
    cmp("sw_iret", 32'(in_service), 32'd0);

    // priority and stability while presenting
    ext_irq = 32'h220; tick(); ext_irq = '0; tick();
    cmp("pri_id5", 32'(irq_id), 32'd5);
    ext_irq = 32'h2; tick(); ext_irq = '0; tick();
    cmp("pri_stable", 32'(irq_id),   32'd5);
    cmp("pri_pend",   pending_out,   32'h222);
    ack_cycle();
    iret_cycle();
    cmp("pri_gap", 32'(irq_valid), 32'd0);
    tick();
    cmp("pri_id1", 32'(irq_id), 32'd1);
    ack_cycle(); iret_cycle(); tick();
    cmp("pri_id9", 32'(irq_id), 32'd9);
    ack_cycle(); iret_cycle(); tick();

    // spurious strobes in IDLE
    iret_in = 1; irq_ack = 1; tick(); idle_inputs(); tick();
    cmp("spur_valid", 32'(irq_valid),  32'd0);
    cmp("spur_serv",  32'(in_service), 32'd0);
    cmp("spur_id",    32'(irq_id),     32'd9);

    // masked source stays pending but is not eligible
    mask_we = 1; mask_in = 32'hFFFF_FFFE; tick(); idle_inputs();
    ext_irq = 32'h1; tick(); ext_irq = '0;
    cmp("mask_pend", pending_out, 32'h1);
    tick(3);
    cmp("mask_blocked", 32'(irq_valid), 32'd0);
    mask_we = 1; mask_in = 32'hFFFF_FFFF; tick(); idle_inputs(); tick();
    cmp("unmask_valid", 32'(irq_valid), 32'd1);
    cmp("unmask_id",    32'(irq_id),    32'd0);
    ack_cycle(); iret_cycle(); tick();

    // masking a presented source does not withdraw it
    ext_irq = 32'h80; tick(); ext_irq = '0; tick();
    mask_we = 1; mask_in = 32'hFFFF_FF7F; tick(); idle_inputs(); tick();
    cmp("req_masked_valid", 32'(irq_valid), 32'd1);
    cmp("req_masked_id",    32'(irq_id),    32'd7);
    mask_we = 1; mask_in = 32'hFFFF_FFFF; tick(); idle_inputs();
    ack_cycle(); iret_cycle(); tick();

    // set/clear collision in the ack cycle
    ext_irq = 32'h10; tick(); ext_irq = '0; tick();
    irq_ack = 1; ext_irq = 32'h10; tick(); idle_inputs();
    cmp("coll_serv", 32'(in_service),  32'd1);
    cmp("coll_pend", pending_out,      32'h10);
    iret_cycle(); tick();
    cmp("coll_again", 32'(irq_id), 32'd4);
    ack_cycle();

    // reset while in service
    ext_irq = 32'h30; mask_we = 1; mask_in = 32'h0000_00FF; tick(); idle_inputs();
    cmp("pre_rst_pend", pending_out, 32'h30);
    cmp("pre_rst_serv", 32'(in_service), 32'd1);
    rst = 1; tick(); rst = 0;
    cmp("mrst_valid",  32'(irq_valid),  32'd0);
    cmp("mrst_serv",   32'(in_service), 32'd0);
    cmp("mrst_pend",   pending_out,     32'd0);
    cmp("mrst_mask",   mask_out,        32'hFFFF_FFFF);
    cmp("mrst_vector", irq_vector,      32'h100);
    tick(3);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
